serial_adder_nb: RTL
====================

Name: serial_adder_nb

Overview:
- Bit-serial N-bit adder; the sequential stage wrapped around the team's existing FullAdder_1b cell.
- Latches two WIDTH-bit operands and a carry-in on a start strobe.
- Feeds one LSB pair per clock through a single FullAdder_1b instance, registers its Cout as the next Cin, and shifts Sum into a result register.
- Area-cheap alternative to the ripple 4-bit adder for wide, latency-tolerant datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in, sampled with start
- busy  output  1  high while bits are being added
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry-out, held with sum

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry register and bit counter all 0.
- States:
  - IDLE: start=1 -> latch a, b into shift regs, load carry reg with cin, counter=0, go to ADD.
  - ADD: each cycle:
    - FullAdder_1b inputs: A=sa[0], B=sb[0], Cin=carry reg.
    - Sum bit shifts into the MSB of the result shift reg (result reg shifts right).
    - carry reg <= Cout; sa, sb shift right; counter++.
    - When counter==WIDTH-1 on this edge, go to DONE.
  - DONE: done=1 for exactly this cycle; sum and cout (final carry reg) presented. Next state is IDLE, or ADD if start=1 (back-to-back accept, same latch actions as IDLE).
- busy=1 exactly in ADD. start in ADD is ignored, not queued.
- Latency: start sampled at edge k -> WIDTH bit-edges k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH (WIDTH+1 cycles from the start edge to the done cycle).
- Outputs sum/cout update only on ADD->DONE; stable from DONE until the next completion. The internal result shift reg is not exposed mid-operation.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, WIDTH+1 bits, no truncation.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1.
- Reset mid-ADD: operation aborted, all state to reset values, no done pulse.
- a/b/cin changes after the start edge have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated with sum/cout.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement signed overflow).
  - Needs one extra register capturing the carry reg value at the last ADD cycle.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package serial_adder_pkg:
  - state typedef enum {S_IDLE, S_ADD, S_DONE}, 2 bits.
  - Constant DEFAULT_WIDTH=8.
- Sub-module: one FullAdder_1b instance for the per-bit sum/carry logic; no new sub-module.
- All sequencing lives in serial_adder_nb.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles; done pulse in the 9th cycle after the start edge; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Start held high across completion with a=0x01, b=0x02 then a=0x10, b=0x20:
  - second op accepted in the DONE cycle.
  - done pulses give 0x03 then 0x30, with no IDLE gap.
- start re-asserted mid-ADD with different operands -> ignored; result equals the first operands' sum; exactly one done.
- rst_n low at 4th ADD cycle -> busy=0, done never pulses, sum=0, cout=0; a fresh start after release computes correctly.
- With SERIAL_ADDER_OVF_EN:
  - 0x7F+0x01 -> sum=0x80, ovf=1, cout=0.
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1.
  - 0x40+0x20 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/FullAdder_1b.sv
// One-bit full adder cell.
module FullAdder_1b (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_nb.sv
// Bit-serial WIDTH-bit adder around one FullAdder_1b cell, one bit per clock.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output ovf.
module serial_adder_nb
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [WIDTH-1:0] res_w;
   logic             fa_s;
   logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   FullAdder_1b u_fa (
      .A    (sa_q[0]),
      .B    (sb_q[0]),
      .Cin  (carry_q),
      .Sum  (fa_s),
      .Cout (fa_co)
   );

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      // Newest sum bit enters at the top; after WIDTH-1 shifts res_q
      // holds bits 0..WIDTH-2 and fa_s is the MSB.
      res_w   = {fa_s, res_q};
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_ADD;
               sa_d    = a;
               sb_d    = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         S_ADD: begin
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            res_d   = res_w[WIDTH-1:1];
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               sum_d   = res_w;
               cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_co;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == S_ADD);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
